// File: rtl/sky130_ef_ip__xtal_osc_ctrl_pkg.sv
// Shared types and default constants for the crystal oscillator controller.
package sky130_ef_ip__xtal_osc_ctrl_pkg;

   typedef enum logic [2:0] {
      StOff     = 3'd0,
      StStartup = 3'd1,
      StMeasure = 3'd2,
      StRun     = 3'd3,
      StStandby = 3'd4,
      StFail    = 3'd5
   } osc_state_e;

   localparam int unsigned SettleCycDefault = 1024;
   localparam int unsigned WinCycDefault    = 256;
   localparam int unsigned MinEdgesDefault  = 72;
   localparam int unsigned MaxEdgesDefault  = 92;
   localparam int unsigned RetryMaxDefault  = 3;

   function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
      return (inc && (v != 8'hff)) ? v + 8'd1 : v;
   endfunction

endpackage

// File: rtl/sky130_ef_ip__xtal_osc_ctrl_if.sv
// Control/status bundle between software, the oscillator pins and the controller.
interface sky130_ef_ip__xtal_osc_ctrl_if;

   logic       en_req;
   logic       stby_req;
   logic       xtal_dout;
   logic       xtal_ena;
   logic       xtal_stdby;
   logic       clk_good;
   logic       fail;
   logic [2:0] state;
   logic [7:0] last_count;

   modport master (
      output en_req, stby_req, xtal_dout,
      input  xtal_ena, xtal_stdby, clk_good, fail, state, last_count
   );

   modport slave (
      input  en_req, stby_req, xtal_dout,
      output xtal_ena, xtal_stdby, clk_good, fail, state, last_count
   );

endinterface

// File: rtl/sky130_ef_ip__xtal_osc_ctrl_fmeter.sv
// Frequency meter: synchronises xtal_dout, counts rising edges per window and
// emits a registered window-done pulse with the final (saturated) count.
module sky130_ef_ip__xtal_osc_ctrl_fmeter
   import sky130_ef_ip__xtal_osc_ctrl_pkg::*;
#(
   parameter int unsigned WIN_CYC = WinCycDefault
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_i,
   input  logic       xtal_dout_i,
   output logic       done_o,
   output logic [7:0] count_o
);

   localparam int unsigned WinW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

   // [0],[1] synchroniser, [2] previous synchronised value for edge detect
   logic [2:0]      sync_q;
   logic [WinW-1:0] win_q, win_d;
   logic [7:0]      edges_q, edges_d;
   logic [7:0]      count_q, count_d;
   logic            done_q;
   logic            rise;
   logic            win_end;

   assign rise    = sync_q[1] & ~sync_q[2];
   assign win_end = run_i && (win_q == WinW'(WIN_CYC - 1));

   always_comb begin
      win_d   = '0;
      edges_d = '0;
      count_d = count_q;
      if (run_i) begin
         win_d   = win_end ? '0 : win_q + 1'b1;
         edges_d = win_end ? '0 : sat_inc(edges_q, rise);
      end
      if (win_end) count_d = sat_inc(edges_q, rise);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         win_q   <= '0;
         edges_q <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], xtal_dout_i};
         win_q   <= win_d;
         edges_q <= edges_d;
         count_q <= count_d;
         done_q  <= win_end;
      end
   end

   assign done_o  = done_q;
   assign count_o = count_q;

endmodule

// File: rtl/sky130_ef_ip__xtal_osc_ctrl.sv
// Crystal oscillator controller: sequences enable/standby, checks frequency
// each window and reports clock-good or failure.
module sky130_ef_ip__xtal_osc_ctrl
   import sky130_ef_ip__xtal_osc_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = SettleCycDefault,
   parameter int unsigned WIN_CYC    = WinCycDefault,
   parameter int unsigned MIN_EDGES  = MinEdgesDefault,
   parameter int unsigned MAX_EDGES  = MaxEdgesDefault,
   parameter int unsigned RETRY_MAX  = RetryMaxDefault
) (
   input logic                         clk,
   input logic                         rst_n,
   sky130_ef_ip__xtal_osc_ctrl_if.slave osc
);

   localparam int unsigned SetW   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned RetryW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

   osc_state_e        state_q, state_d;
   logic [SetW-1:0]   settle_q, settle_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic              ena_q, stdby_q, good_q, fail_q;
   logic [7:0]        last_q;
   logic              run;
   logic              win_done;
   logic [7:0]        win_count;
   logic              in_range;

   assign run      = (state_q == StMeasure) || (state_q == StRun);
   assign in_range = (win_count >= 8'(MIN_EDGES)) && (win_count <= 8'(MAX_EDGES));

   sky130_ef_ip__xtal_osc_ctrl_fmeter #(
      .WIN_CYC (WIN_CYC)
   ) u_fmeter (
      .clk         (clk),
      .rst_n       (rst_n),
      .run_i       (run),
      .xtal_dout_i (osc.xtal_dout),
      .done_o      (win_done),
      .count_o     (win_count)
   );

   always_comb begin
      state_d  = state_q;
      settle_d = '0;
      retry_d  = retry_q;
      case (state_q)
         StOff: begin
            if (osc.en_req) begin
               state_d = StStartup;
               retry_d = '0;
            end
         end
         StStartup: begin
            settle_d = settle_q + 1'b1;
            if (settle_q == SetW'(SETTLE_CYC - 1)) begin
               state_d  = StMeasure;
               settle_d = '0;
            end
         end
         StMeasure: begin
            if (win_done) begin
               if (in_range) begin
                  state_d = StRun;
               end else if (retry_q < RetryW'(RETRY_MAX)) begin
                  state_d = StStartup;
                  retry_d = retry_q + 1'b1;
               end else begin
                  state_d = StFail;
               end
            end
         end
         StRun: begin
            if (win_done && !in_range) state_d = StFail;
            else if (osc.stby_req)     state_d = StStandby;
         end
         StStandby: begin
            if (!osc.stby_req) begin
               state_d = StStartup;
               retry_d = '0;
            end
         end
         StFail:  state_d = StFail;
         default: state_d = StOff;
      endcase
      // Dropping the enable wins over every other transition.
      if (!osc.en_req) state_d = StOff;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StOff;
         settle_q <= '0;
         retry_q  <= '0;
         ena_q    <= 1'b0;
         stdby_q  <= 1'b0;
         good_q   <= 1'b0;
         fail_q   <= 1'b0;
         last_q   <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         retry_q  <= retry_d;
         ena_q    <= state_d inside {StStartup, StMeasure, StRun, StStandby};
         stdby_q  <= (state_d == StStandby);
         good_q   <= (state_d == StRun);
         fail_q   <= (state_d == StFail);
         if (win_done) last_q <= win_count;
      end
   end

   assign osc.xtal_ena   = ena_q;
   assign osc.xtal_stdby = stdby_q;
   assign osc.clk_good   = good_q;
   assign osc.fail       = fail_q;
   assign osc.state      = state_q;
   assign osc.last_count = last_q;

endmodule

// File: tb/tb_sky130_ef_ip__xtal_osc_ctrl.sv
// Directed bench for the crystal oscillator controller (time unit 1 ps).
module tb_sky130_ef_ip__xtal_osc_ctrl;

   logic clk;
   logic rst_n;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned xtal_half = 31250;
   bit          xtal_on = 1'b0;

   sky130_ef_ip__xtal_osc_ctrl_if osc_if ();

   sky130_ef_ip__xtal_osc_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .osc   (osc_if)
   );

   initial begin
      clk = 1'b0;
      forever #10000 clk = ~clk;
   end

   initial begin
      osc_if.xtal_dout = 1'b0;
      forever begin
         if (xtal_on) begin
            #(xtal_half);
            osc_if.xtal_dout = ~osc_if.xtal_dout;
         end else begin
            osc_if.xtal_dout = 1'b0;
            #1000;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      osc_if.en_req = 1'b0;
      osc_if.stby_req = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      osc_if.en_req = 1'b1;
      osc_if.stby_req = 1'b1;
      xtal_on = 1'b1;
      tick(3);
      n_cmp++; if (osc_if.state !== 3'd0) begin $display("FAIL reset_state got=%0d want=0", osc_if.state); n_bad++; end
      n_cmp++; if (osc_if.xtal_ena !== 1'b0) begin $display("FAIL reset_ena got=%b want=0", osc_if.xtal_ena); n_bad++; end
      n_cmp++; if (osc_if.xtal_stdby !== 1'b0) begin $display("FAIL reset_stdby got=%b want=0", osc_if.xtal_stdby); n_bad++; end
      n_cmp++; if (osc_if.clk_good !== 1'b0) begin $display("FAIL reset_good got=%b want=0", osc_if.clk_good); n_bad++; end
      n_cmp++; if (osc_if.fail !== 1'b0) begin $display("FAIL reset_fail got=%b want=0", osc_if.fail); n_bad++; end
      n_cmp++; if (osc_if.last_count !== 8'd0) begin $display("FAIL reset_count got=%0d want=0", osc_if.last_count); n_bad++; end
   endtask

   // Starts from reset; leaves the DUT in RUN at cycle 1282 with a 16 MHz crystal.
   task automatic test_startup();
      xtal_half = 31250;
      xtal_on = 1'b1;
      do_reset();
      osc_if.en_req = 1'b1;
      tick(1);
      n_cmp++; if (osc_if.xtal_ena !== 1'b1) begin $display("FAIL start_ena_c1 got=%b want=1", osc_if.xtal_ena); n_bad++; end
      n_cmp++; if (osc_if.state !== 3'd1) begin $display("FAIL start_state_c1 got=%0d want=1", osc_if.state); n_bad++; end
      osc_if.stby_req = 1'b1;
      tick(10);
      n_cmp++; if (osc_if.state !== 3'd1 || osc_if.xtal_stdby !== 1'b0) begin
         $display("FAIL start_stby_ignored got=%0d/%b want=1/0", osc_if.state, osc_if.xtal_stdby); n_bad++; end
      osc_if.stby_req = 1'b0;
      tick(1013);
      n_cmp++; if (osc_if.state !== 3'd1) begin $display("FAIL start_state_c1024 got=%0d want=1", osc_if.state); n_bad++; end
      tick(1);
      n_cmp++; if (osc_if.state !== 3'd2) begin $display("FAIL start_measure_c1025 got=%0d want=2", osc_if.state); n_bad++; end
      tick(256);
      n_cmp++; if (osc_if.clk_good !== 1'b0) begin $display("FAIL start_good_c1281 got=%b want=0", osc_if.clk_good); n_bad++; end
      tick(1);
      n_cmp++; if (osc_if.clk_good !== 1'b1) begin $display("FAIL start_good_c1282 got=%b want=1", osc_if.clk_good); n_bad++; end
      n_cmp++; if (osc_if.state !== 3'd3) begin $display("FAIL start_run_c1282 got=%0d want=3", osc_if.state); n_bad++; end
      n_cmp++; if ($isunknown(osc_if.last_count) || osc_if.last_count < 8'd81 || osc_if.last_count > 8'd83) begin
         $display("FAIL start_count got=%0d want=81..83", osc_if.last_count); n_bad++; end
   endtask

   // Continues from RUN at cycle 1282; crystal jumps to 20 MHz at a window boundary.
   task automatic test_drift();
      xtal_half = 25000;
      tick(255);
      n_cmp++; if (osc_if.clk_good !== 1'b1) begin $display("FAIL drift_good_before got=%b want=1", osc_if.clk_good); n_bad++; end
      tick(1);
      n_cmp++; if (osc_if.clk_good !== 1'b0) begin $display("FAIL drift_good got=%b want=0", osc_if.clk_good); n_bad++; end
      n_cmp++; if (osc_if.fail !== 1'b1) begin $display("FAIL drift_fail got=%b want=1", osc_if.fail); n_bad++; end
      n_cmp++; if (osc_if.state !== 3'd5 || osc_if.xtal_ena !== 1'b0) begin
         $display("FAIL drift_state got=%0d/%b want=5/0", osc_if.state, osc_if.xtal_ena); n_bad++; end
      n_cmp++; if ($isunknown(osc_if.last_count) || osc_if.last_count < 8'd99 || osc_if.last_count > 8'd105) begin
         $display("FAIL drift_count got=%0d want=99..105", osc_if.last_count); n_bad++; end
      tick(4);
      n_cmp++; if (osc_if.fail !== 1'b1) begin $display("FAIL drift_fail_hold got=%b want=1", osc_if.fail); n_bad++; end
      osc_if.en_req = 1'b0;
      tick(1);
      n_cmp++; if (osc_if.state !== 3'd0 || osc_if.fail !== 1'b0) begin
         $display("FAIL drift_off got=%0d/%b want=0/0", osc_if.state, osc_if.fail); n_bad++; end
   endtask

   task automatic test_stuck();
      logic [2:0] want_state;
      xtal_on = 1'b0;
      do_reset();
      osc_if.en_req = 1'b1;
      tick(1);
      for (int a = 0; a < 4; a++) begin
         tick(1281);
         want_state = (a < 3) ? 3'd1 : 3'd5;
         n_cmp++; if (osc_if.last_count !== 8'd0) begin
            $display("FAIL stuck_count[%0d] got=%0d want=0", a, osc_if.last_count); n_bad++; end
         n_cmp++; if (osc_if.state !== want_state) begin
            $display("FAIL stuck_state[%0d] got=%0d want=%0d", a, osc_if.state, want_state); n_bad++; end
      end
      n_cmp++; if (osc_if.fail !== 1'b1 || osc_if.xtal_ena !== 1'b0) begin
         $display("FAIL stuck_fail got=%b/%b want=1/0", osc_if.fail, osc_if.xtal_ena); n_bad++; end
      osc_if.en_req = 1'b0;
      tick(1);
      n_cmp++; if (osc_if.state !== 3'd0 || osc_if.fail !== 1'b0) begin
         $display("FAIL stuck_off got=%0d/%b want=0/0", osc_if.state, osc_if.fail); n_bad++; end
   endtask

   task automatic test_standby();
      xtal_half = 31250;
      xtal_on = 1'b1;
      do_reset();
      osc_if.en_req = 1'b1;
      tick(1282);
      n_cmp++; if (osc_if.clk_good !== 1'b1) begin $display("FAIL stby_pre_good got=%b want=1", osc_if.clk_good); n_bad++; end
      osc_if.stby_req = 1'b1;
      tick(1);
      n_cmp++; if (osc_if.state !== 3'd4 || osc_if.xtal_stdby !== 1'b1) begin
         $display("FAIL stby_enter got=%0d/%b want=4/1", osc_if.state, osc_if.xtal_stdby); n_bad++; end
      n_cmp++; if (osc_if.clk_good !== 1'b0 || osc_if.xtal_ena !== 1'b1) begin
         $display("FAIL stby_outs got=%b/%b want=0/1", osc_if.clk_good, osc_if.xtal_ena); n_bad++; end
      tick(20);
      n_cmp++; if (osc_if.state !== 3'd4) begin $display("FAIL stby_hold got=%0d want=4", osc_if.state); n_bad++; end
      osc_if.stby_req = 1'b0;
      tick(1);
      n_cmp++; if (osc_if.state !== 3'd1 || osc_if.xtal_stdby !== 1'b0) begin
         $display("FAIL stby_exit got=%0d/%b want=1/0", osc_if.state, osc_if.xtal_stdby); n_bad++; end
      tick(1280);
      n_cmp++; if (osc_if.clk_good !== 1'b0) begin $display("FAIL stby_good_early got=%b want=0", osc_if.clk_good); n_bad++; end
      tick(1);
      n_cmp++; if (osc_if.clk_good !== 1'b1) begin $display("FAIL stby_good_back got=%b want=1", osc_if.clk_good); n_bad++; end
   endtask

   task automatic test_abort();
      xtal_half = 31250;
      xtal_on = 1'b1;
      do_reset();
      osc_if.en_req = 1'b1;
      tick(1281);
      n_cmp++; if (osc_if.state !== 3'd2) begin $display("FAIL abort_measure got=%0d want=2", osc_if.state); n_bad++; end
      osc_if.en_req = 1'b0;
      tick(1);
      n_cmp++; if (osc_if.state !== 3'd0 || osc_if.clk_good !== 1'b0) begin
         $display("FAIL abort_off got=%0d/%b want=0/0", osc_if.state, osc_if.clk_good); n_bad++; end
      tick(5);
      n_cmp++; if (osc_if.state !== 3'd0 || osc_if.fail !== 1'b0 || osc_if.xtal_ena !== 1'b0) begin
         $display("FAIL abort_stay got=%0d/%b/%b want=0/0/0", osc_if.state, osc_if.fail, osc_if.xtal_ena); n_bad++; end
   endtask

   task automatic test_reset_mid_run();
      xtal_half = 31250;
      xtal_on = 1'b1;
      do_reset();
      osc_if.en_req = 1'b1;
      tick(1290);
      n_cmp++; if (osc_if.clk_good !== 1'b1) begin $display("FAIL mid_pre_good got=%b want=1", osc_if.clk_good); n_bad++; end
      #3000;
      rst_n = 1'b0;
      #1000;
      n_cmp++; if (osc_if.clk_good !== 1'b0 || osc_if.xtal_ena !== 1'b0 || osc_if.state !== 3'd0) begin
         $display("FAIL mid_async got=%b/%b/%0d want=0/0/0", osc_if.clk_good, osc_if.xtal_ena, osc_if.state); n_bad++; end
      n_cmp++; if (osc_if.last_count !== 8'd0 || osc_if.fail !== 1'b0 || osc_if.xtal_stdby !== 1'b0) begin
         $display("FAIL mid_async2 got=%0d/%b/%b want=0/0/0", osc_if.last_count, osc_if.fail, osc_if.xtal_stdby); n_bad++; end
      #1000;
      rst_n = 1'b1;
      tick(1);
      n_cmp++; if (osc_if.state !== 3'd1 || osc_if.xtal_ena !== 1'b1) begin
         $display("FAIL mid_resume got=%0d/%b want=1/1", osc_if.state, osc_if.xtal_ena); n_bad++; end
   endtask

   initial begin
      rst_n = 1'b0;
      osc_if.en_req = 1'b0;
      osc_if.stby_req = 1'b0;
      test_reset();
      test_startup();
      test_drift();
      test_stuck();
      test_standby();
      test_abort();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
